// File: rtl/wifi_at_pkg.sv
// rtl/wifi_at_pkg.sv - state encoding, AT command ROM and baud divider for the WiFi AT transmitter
//
// Purpose: shared constants for wifi_at_tx and at_tx_serializer.
//   ST_*          command FSM state encoding
//   AT_ROM        one AT_MAX_LEN-byte slot per command, text right-aligned, first character highest
//   AT_LEN        byte count of each command including the trailing CR LF
//   calc_baud_div system clock cycles per UART bit
//   rom_byte      byte idx of command sel

package wifi_at_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam int AT_MAX_LEN = 24;
    localparam logic [15:0] CRLF = 16'h0D0A;

    typedef logic [AT_MAX_LEN*8-1:0] at_slot_t;

    localparam at_slot_t AT_ROM [4] = '{
        at_slot_t'({"AT", CRLF}),
        at_slot_t'({"AT+CWMODE=1", CRLF}),
        at_slot_t'({"AT+CIPMUX=1", CRLF}),
        at_slot_t'({"AT+CIPSERVER=1,8080", CRLF})
    };

    localparam int AT_LEN [4] = '{4, 13, 13, 21};

    function automatic int calc_baud_div(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

    // Text is right-aligned in its slot, so character idx sits (len-1-idx) bytes above bit 0.
    function automatic logic [7:0] rom_byte(input logic [1:0] sel, input int idx);
        at_slot_t slot;
        int       len;
        slot = AT_ROM[sel];
        len  = AT_LEN[sel];
        if (idx >= len) begin
            return 8'hFF;
        end
        return slot[(len - 1 - idx) * 8 +: 8];
    endfunction

endpackage

// File: rtl/at_tx_serializer.sv
// rtl/at_tx_serializer.sv - one-byte 8N1 shifter with baud counter
//
// Purpose: shifts start, 8 data bits LSB first and stop out of a registered line output.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_load     capture i_byte as a new frame and restart the baud counter
//   i_byte     byte to send
//   i_en       frame in progress; baud counter held at 0 and line forced high when low
//   o_tx       serial line, straight from a flop
//   o_bit_done last cycle of the current bit

module at_tx_serializer #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_en,
    output logic       o_tx,
    output logic       o_bit_done
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [9:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_done;

    assign bit_done = i_en && (baud_cnt_q == BAUD_W'(BAUD_DIV - 1));

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        shift_d    = shift_q;
        if (i_load) begin
            shift_d    = {1'b1, i_byte, 1'b0};
            baud_cnt_d = '0;
        end else if (i_en) begin
            if (bit_done) begin
                baud_cnt_d = '0;
                shift_d    = {1'b1, shift_q[9:1]};
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
            end
        end else begin
            baud_cnt_d = '0;
        end
        // The line trails the shift register by one cycle, keeping every bit exactly BAUD_DIV wide.
        tx_d = i_en ? shift_q[0] : 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            baud_cnt_q <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx       = tx_q;
    assign o_bit_done = bit_done;

endmodule

// File: rtl/wifi_at_tx.sv
// rtl/wifi_at_tx.sv - sends one of four fixed AT command strings over UART 8N1
//
// Purpose: command FSM, byte index and inter-byte gap timing around at_tx_serializer.
// Ports:
//   i_clk_sys   system clock
//   i_rst       synchronous reset, active-high
//   i_cmd_sel   command index 0..3
//   i_cmd_start request, sampled only in IDLE
//   o_busy      command in progress
//   o_cmd_done  one-cycle pulse once the last stop bit has left the line
//   o_byte_cnt  bytes fully sent in the current command
//   o_uart_tx   serial line, idle high

module wifi_at_tx
    import wifi_at_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 9600,
    parameter int GAP_BITS  = 1,
    parameter int MAX_LEN   = 24
) (
    input  logic       i_clk_sys,
    input  logic       i_rst,
    input  logic [1:0] i_cmd_sel,
    input  logic       i_cmd_start,
    output logic       o_busy,
    output logic       o_cmd_done,
    output logic [4:0] o_byte_cnt,
    output logic       o_uart_tx
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FRE, BAUD_RATE);
    // The LOAD cycle supplies the final gap cycle, so GAP itself is one cycle short.
    localparam int GAP_HOLD = (GAP_BITS * BAUD_DIV > 0) ? GAP_BITS * BAUD_DIV - 1 : 0;
    localparam int GAP_W    = (GAP_HOLD > 1) ? $clog2(GAP_HOLD) : 1;
    localparam int IDX_W    = $clog2(MAX_LEN + 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [4:0]       byte_cnt_q, byte_cnt_d;

    logic             ser_load;
    logic             ser_en;
    logic             bit_done;
    logic [7:0]       load_byte;

    assign ser_load  = (state_q == ST_LOAD);
    assign ser_en    = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign load_byte = rom_byte(sel_q, int'(idx_q));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_start) begin
                    sel_d   = i_cmd_sel;
                    len_d   = IDX_W'(AT_LEN[i_cmd_sel]);
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                    else bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == len_q) begin
                        state_d = ST_DONE;
                    end else if (GAP_HOLD > 0) begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_HOLD - 1)) state_d = ST_LOAD;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Status outputs are registered from the state so they line up with the registered line.
        busy_d     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_d     = (state_q == ST_DONE);
        byte_cnt_d = 5'(idx_q);
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    at_tx_serializer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_serializer (
        .i_clk      (i_clk_sys),
        .i_rst      (i_rst),
        .i_load     (ser_load),
        .i_byte     (load_byte),
        .i_en       (ser_en),
        .o_tx       (o_uart_tx),
        .o_bit_done (bit_done)
    );

    assign o_busy     = busy_q;
    assign o_cmd_done = done_q;
    assign o_byte_cnt = byte_cnt_q;

endmodule
